// File: rtl/aes_dec_pkg.sv
// aes_dec_pkg: AES-128 constants, GF(2^8) arithmetic and inverse-round helpers
// shared by the iterative decrypter.
package aes_dec_pkg;
   localparam int NR = 10;
   localparam logic [7:0] RCON [1:NR] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                          8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
   typedef enum logic [2:0] {IDLE, KEXP, ADDK, ROUND, DONE} state_e;

   function automatic logic [7:0] mul2(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] mul9(input logic [7:0] a);
      return mul2(mul2(mul2(a))) ^ a;
   endfunction

   function automatic logic [7:0] mul11(input logic [7:0] a);
      return mul2(mul2(mul2(a))) ^ mul2(a) ^ a;
   endfunction

   function automatic logic [7:0] mul13(input logic [7:0] a);
      return mul2(mul2(mul2(a))) ^ mul2(mul2(a)) ^ a;
   endfunction

   function automatic logic [7:0] mul14(input logic [7:0] a);
      return mul2(mul2(mul2(a))) ^ mul2(mul2(a)) ^ mul2(a);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         p = b[i] ? p ^ x : p;
         x = mul2(x);
      end
      return p;
   endfunction

   // a^254 is the multiplicative inverse; 0 maps to 0 as the S-box requires
   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] p, q;
      p = a;
      q = 8'h01;
      for (int i = 0; i < 7; i++) begin
         p = gmul(p, p);
         q = gmul(q, p);
      end
      return q;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
      return (a << n) | (a >> (8 - n));
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = ginv(a);
      return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
   endfunction

   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8];
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0] a [4];
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) a[r] = s[127 - 8 * (4 * c + r) -: 8];
         for (int r = 0; r < 4; r++)
            o[127 - 8 * (4 * c + r) -: 8] = mul14(a[r]) ^ mul11(a[(r + 1) % 4]) ^
                                            mul13(a[(r + 2) % 4]) ^ mul9(a[(r + 3) % 4]);
      end
      return o;
   endfunction
endpackage

// File: rtl/aes_dec_round_ctrl_if.sv
// aes_dec_round_ctrl_if: ciphertext-in / plaintext-out valid/ready bundle.
interface aes_dec_round_ctrl_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] cipher_text;
   logic [127:0] key;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] plain_text;
   logic         busy;
   modport master (output in_valid, cipher_text, key, out_ready,
                   input in_ready, out_valid, plain_text, busy);
   modport slave (input in_valid, cipher_text, key, out_ready,
                  output in_ready, out_valid, plain_text, busy);
endinterface

// File: rtl/aes_dec_round.sv
// aes_dec_round: one combinational AES inverse round; last skips InvMixColumns.
module aes_dec_round
   import aes_dec_pkg::*;
(
   input  logic [127:0] state,
   input  logic [127:0] rk,
   input  logic         last,
   output logic [127:0] next_state
);
   logic [127:0] sr, sb, ark;
   assign sr = inv_shift_rows(state);
   for (genvar i = 0; i < 16; i++) begin : g_sb
      assign sb[8 * i +: 8] = inv_sbox(sr[8 * i +: 8]);
   end
   assign ark = sb ^ rk;
   assign next_state = last ? ark : inv_mix_columns(ark);
endmodule

// File: rtl/aes_dec_round_ctrl.sv
// aes_dec_round_ctrl: iterative AES-128 decrypter, one inverse round per clock.
// Define AES_DEC_KEY_CACHE_EN to keep the last expanded key and skip re-expansion on a repeat.
module aes_dec_round_ctrl
   import aes_dec_pkg::*;
(
   input logic clk,
   input logic rst_n,
   aes_dec_round_ctrl_if.slave bus
);
   state_e state, nxt;
   logic [127:0] rk [0:NR];
   logic [127:0] ct, st, pt, prev, rnd_out;
   logic [31:0] tw, k0, k1, k2, k3;
   logic [3:0] kidx, r;
   logic acc, hit;

   assign bus.in_ready = rst_n && state == IDLE;
   assign bus.busy = state != IDLE;
   assign bus.out_valid = state == DONE;
   assign bus.plain_text = pt;
   assign acc = bus.in_valid && bus.in_ready;

   // forward key schedule step producing rk[kidx] from rk[kidx-1]
   assign prev = rk[kidx - 4'd1];
   assign tw = {sbox(prev[23:16]), sbox(prev[15:8]), sbox(prev[7:0]), sbox(prev[31:24])} ^
               {RCON[kidx], 24'h0};
   assign k0 = prev[127:96] ^ tw;
   assign k1 = prev[95:64] ^ k0;
   assign k2 = prev[63:32] ^ k1;
   assign k3 = prev[31:0] ^ k2;

   aes_dec_round u_round (
      .state(st),
      .rk(rk[r]),
      .last(r == 4'd0),
      .next_state(rnd_out)
   );

`ifdef AES_DEC_KEY_CACHE_EN
   logic cache_vld;
   assign hit = cache_vld && bus.key == rk[0];
   always_ff @(posedge clk) begin
      if (!rst_n) cache_vld <= 1'b0;
      else if (acc && !hit) cache_vld <= 1'b0;
      else if (state == KEXP && kidx == 4'(NR)) cache_vld <= 1'b1;
   end
`else
   assign hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = acc ? (hit ? ADDK : KEXP) : IDLE;
         KEXP:    nxt = kidx == 4'(NR) ? ADDK : KEXP;
         ADDK:    nxt = ROUND;
         ROUND:   nxt = r == 4'd0 ? DONE : ROUND;
         DONE:    nxt = bus.out_ready ? IDLE : DONE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (acc) begin
         ct <= bus.cipher_text;
         rk[0] <= bus.key;
         kidx <= 4'd1;
      end
      if (state == KEXP) begin
         rk[kidx] <= {k0, k1, k2, k3};
         kidx <= kidx + 4'd1;
      end
      if (state == ADDK) begin
         st <= ct ^ rk[NR];
         r <= 4'(NR - 1);
      end
      if (state == ROUND) begin
         st <= rnd_out;
         r <= r - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) pt <= '0;
      else if (state == ROUND && r == 4'd0) pt <= rnd_out;
   end
endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// tb_aes_dec_round_ctrl: randomized self-checking bench; the reference encrypts
// plaintext with a forward AES model and expects the DUT to recover it.
module tb_aes_dec_round_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int passed = 0;
   int total = 0;
   logic [7:0] sbox_t [256];
   logic [127:0] m_key = '0;
   bit m_vld = 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
   localparam bit CACHE = 1'b1;
`else
   localparam bit CACHE = 1'b0;
`endif

   always #5 clk = ~clk;

   aes_dec_round_ctrl_if bus ();
   aes_dec_round_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   function automatic logic [7:0] xt(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   task automatic build_sbox();
      logic [7:0] p, q, x;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ (q << 1);
         q = q ^ (q << 2);
         q = q ^ (q << 4);
         if (q[7]) q = q ^ 8'h09;
         x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
         sbox_t[p] = x ^ 8'h63;
      end while (p != 8'h01);
      sbox_t[0] = 8'h63;
   endtask

   function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] k);
      logic [127:0] rk [11];
      logic [7:0] a [16];
      logic [7:0] t [16];
      logic [31:0] w [4];
      logic [31:0] tw;
      logic [7:0] rc;
      logic [127:0] o;
      rk[0] = k;
      rc = 8'h01;
      for (int i = 1; i < 11; i++) begin
         for (int j = 0; j < 4; j++) w[j] = rk[i - 1][127 - 32 * j -: 32];
         tw = {sbox_t[w[3][23:16]], sbox_t[w[3][15:8]], sbox_t[w[3][7:0]], sbox_t[w[3][31:24]]} ^ {rc, 24'h0};
         w[0] = w[0] ^ tw;
         w[1] = w[1] ^ w[0];
         w[2] = w[2] ^ w[1];
         w[3] = w[3] ^ w[2];
         rk[i] = {w[0], w[1], w[2], w[3]};
         rc = xt(rc);
      end
      for (int j = 0; j < 16; j++) a[j] = pt[127 - 8 * j -: 8] ^ k[127 - 8 * j -: 8];
      for (int rn = 1; rn < 11; rn++) begin
         for (int j = 0; j < 16; j++) t[j] = sbox_t[a[4 * ((j / 4 + j % 4) % 4) + j % 4]];
         for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
               a[4 * c + rr] = (rn == 10) ? t[4 * c + rr] :
                  xt(t[4 * c + rr]) ^ xt(t[4 * c + (rr + 1) % 4]) ^ t[4 * c + (rr + 1) % 4] ^
                  t[4 * c + (rr + 2) % 4] ^ t[4 * c + (rr + 3) % 4];
         for (int j = 0; j < 16; j++) a[j] = a[j] ^ rk[rn][127 - 8 * j -: 8];
      end
      for (int j = 0; j < 16; j++) o[127 - 8 * j -: 8] = a[j];
      return o;
   endfunction

   function automatic int exp_lat(input logic [127:0] k);
      return (CACHE && m_vld && k == m_key) ? 12 : 22;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_block(input logic [127:0] k, input logic [127:0] c);
      int n;
      n = 0;
      while (!bus.in_ready && n < 100) begin
         tick();
         n++;
      end
      bus.key = k;
      bus.cipher_text = c;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 1;
      while (!bus.out_valid && lat < 200) begin
         tick();
         lat++;
      end
      if (!bus.out_valid) lat = -1;
   endtask

   task automatic accept_out();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      total++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready got %0b want 0", bus.in_ready); else passed++;
      total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); else passed++;
      total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", bus.busy); else passed++;
      total++; if (bus.plain_text !== '0) $display("FAIL reset_plain_text got %h want 0", bus.plain_text); else passed++;
      rst_n = 1'b1;
      #1;
      total++; if (bus.in_ready !== 1'b1) $display("FAIL release_in_ready got %0b want 1", bus.in_ready); else passed++;
      m_vld = 1'b0;
   endtask

   task automatic test_fips();
      logic [127:0] fk [2];
      logic [127:0] fc [2];
      logic [127:0] fp [2];
      int lat, el;
      fk[0] = 128'h000102030405060708090a0b0c0d0e0f;
      fc[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      fp[0] = 128'h00112233445566778899aabbccddeeff;
      fk[1] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      fc[1] = 128'h3925841d02dc09fbdc118597196a0b32;
      fp[1] = 128'h3243f6a8885a308d313198a2e0370734;
      for (int v = 0; v < 2; v++) begin
         el = exp_lat(fk[v]);
         start_block(fk[v], fc[v]);
         wait_out(lat);
         total++; if (lat !== el) $display("FAIL fips%0d_latency got %0d want %0d", v, lat, el); else passed++;
         total++; if (bus.plain_text !== fp[v]) $display("FAIL fips%0d_pt got %h want %h", v, bus.plain_text, fp[v]); else passed++;
         accept_out();
         m_key = fk[v];
         m_vld = 1'b1;
         total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL fips%0d_release got out_valid=%0b in_ready=%0b want 0/1", v, bus.out_valid, bus.in_ready);
         else passed++;
      end
   endtask

   task automatic test_cache_hit();
      logic [127:0] ks [3];
      logic [127:0] p;
      int lat, el;
      ks[0] = 128'h000102030405060708090a0b0c0d0e0f;
      ks[1] = ks[0];
      ks[2] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      p = 128'h00112233445566778899aabbccddeeff;
      for (int v = 0; v < 3; v++) begin
         el = exp_lat(ks[v]);
         start_block(ks[v], aes_enc(p, ks[v]));
         wait_out(lat);
         total++; if (lat !== el) $display("FAIL cache%0d_latency got %0d want %0d", v, lat, el); else passed++;
         total++; if (bus.plain_text !== p) $display("FAIL cache%0d_pt got %h want %h", v, bus.plain_text, p); else passed++;
         accept_out();
         m_key = ks[v];
         m_vld = 1'b1;
      end
   endtask

   task automatic test_random();
      logic [127:0] k, p;
      int lat, el;
      for (int v = 0; v < 8; v++) begin
         k = (m_vld && $urandom_range(0, 1) == 1) ? m_key : rnd128();
         p = rnd128();
         el = exp_lat(k);
         start_block(k, aes_enc(p, k));
         wait_out(lat);
         total++; if (lat !== el) $display("FAIL rand%0d_latency got %0d want %0d", v, lat, el); else passed++;
         total++; if (bus.plain_text !== p) $display("FAIL rand%0d_pt got %h want %h", v, bus.plain_text, p); else passed++;
         accept_out();
         m_key = k;
         m_vld = 1'b1;
      end
   endtask

   task automatic test_back_pressure();
      logic [127:0] k, p;
      int lat, el, bad;
      k = rnd128();
      p = rnd128();
      el = exp_lat(k);
      start_block(k, aes_enc(p, k));
      wait_out(lat);
      total++; if (lat !== el) $display("FAIL bp_latency got %0d want %0d", lat, el); else passed++;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (bus.plain_text !== p || bus.in_ready !== 1'b0 || bus.busy !== 1'b1 || bus.out_valid !== 1'b1) bad++;
      end
      total++; if (bad != 0) $display("FAIL bp_hold got %0d bad cycles (pt=%h) want 0 (pt=%h)", bad, bus.plain_text, p); else passed++;
      accept_out();
      m_key = k;
      m_vld = 1'b1;
      total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
         $display("FAIL bp_release got out_valid=%0b in_ready=%0b want 0/1", bus.out_valid, bus.in_ready);
      else passed++;
   endtask

   task automatic test_reset_mid();
      logic [127:0] k, p, c;
      int lat, el, seen;
      k = rnd128();
      p = rnd128();
      c = aes_enc(p, k);
      start_block(k, c);
      repeat (14) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      m_vld = 1'b0;
      #1;
      total++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0)
         $display("FAIL rstmid_idle got in_ready=%0b busy=%0b want 1/0", bus.in_ready, bus.busy);
      else passed++;
      total++; if (bus.plain_text !== '0) $display("FAIL rstmid_pt got %h want 0", bus.plain_text); else passed++;
      seen = 0;
      repeat (30) begin
         tick();
         if (bus.out_valid) seen++;
      end
      total++; if (seen != 0) $display("FAIL rstmid_no_output got %0d out_valid cycles want 0", seen); else passed++;
      el = exp_lat(k);
      start_block(k, c);
      wait_out(lat);
      total++; if (lat !== el) $display("FAIL rstmid_relatency got %0d want %0d", lat, el); else passed++;
      total++; if (bus.plain_text !== p) $display("FAIL rstmid_pt2 got %h want %h", bus.plain_text, p); else passed++;
      accept_out();
      m_key = k;
      m_vld = 1'b1;
   endtask

   task automatic test_busy_ignore();
      logic [127:0] k, p;
      int lat, el;
      k = rnd128();
      p = rnd128();
      el = exp_lat(k);
      start_block(k, aes_enc(p, k));
      lat = 1;
      while (!bus.out_valid && lat < 200) begin
         if (lat >= 2 && lat < 10) begin
            bus.in_valid = lat[0];
            bus.key = rnd128();
            bus.cipher_text = rnd128();
         end else bus.in_valid = 1'b0;
         tick();
         lat++;
      end
      bus.in_valid = 1'b0;
      if (!bus.out_valid) lat = -1;
      total++; if (lat !== el) $display("FAIL busy_latency got %0d want %0d", lat, el); else passed++;
      total++; if (bus.plain_text !== p) $display("FAIL busy_pt got %h want %h", bus.plain_text, p); else passed++;
      accept_out();
      m_key = k;
      m_vld = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.key = '0;
      bus.cipher_text = '0;
      build_sbox();
      test_reset();
      test_fips();
      test_cache_hit();
      test_random();
      test_back_pressure();
      test_reset_mid();
      test_busy_ignore();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
